// File: rtl/spi_mosi_rx_buffer.sv
// SPI MOSI receiver: shifts bytes MSB-first while CS is low and collects them,
// with their DC flags, into an N-slot buffer the consumer empties with i_CLEAR.
module spi_mosi_rx_buffer #(
    parameter int WIDTH = 8,
    parameter int N     = 8
) (
    input  logic                 i_SCK,
    input  logic                 i_RST,
    input  logic                 i_MOSI,
    input  logic                 i_CS,
    input  logic                 i_DC,
    input  logic                 i_CLEAR,
    output logic [WIDTH*N-1:0]   o_DATA,
    output logic [N-1:0]         o_DC,
    output logic [4:0]           o_N_received,
    output logic [WIDTH-1:0]     o_BYTE,
    output logic                 o_BYTE_VALID,
    output logic                 o_FRAME_DONE,
    output logic                 o_FULL,
    output logic                 o_OVERFLOW,
    output logic                 o_PARTIAL
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   bit_cnt_reg, bit_cnt_next;
    logic [WIDTH-1:0]   shift_reg, shift_next;
    logic               byte_seen_reg, byte_seen_next;
    logic [WIDTH-1:0]   shift_word;
    logic               byte_done;
    logic               frame_end;
    logic               partial_drop;
    logic               has_room;

    always_comb begin
        state_next     = state_reg;
        bit_cnt_next   = bit_cnt_reg;
        shift_next     = shift_reg;
        byte_seen_next = byte_seen_reg;
        byte_done      = 1'b0;
        frame_end      = 1'b0;
        partial_drop   = 1'b0;
        // Truncating cast keeps the low WIDTH bits, i.e. shift left with MOSI in the LSB.
        shift_word     = WIDTH'({shift_reg, i_MOSI});

        if (!i_CS) begin
            shift_next = shift_word;
            if (bit_cnt_reg == LAST_BIT) begin
                byte_done    = 1'b1;
                bit_cnt_next = '0;
            end else begin
                bit_cnt_next = bit_cnt_reg + 1'b1;
            end
        end else if (bit_cnt_reg != '0) begin
            partial_drop = 1'b1;
            bit_cnt_next = '0;
            shift_next   = '0;
        end

        case (state_reg)
            IDLE: begin
                if (!i_CS) begin
                    state_next     = SHIFT;
                    byte_seen_next = byte_done;
                end
            end
            SHIFT: begin
                if (i_CS) begin
                    state_next     = IDLE;
                    frame_end      = byte_seen_reg;
                    byte_seen_next = 1'b0;
                end else if (byte_done) begin
                    byte_seen_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_SCK) begin
        if (i_RST) begin
            state_reg     <= IDLE;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            byte_seen_reg <= 1'b0;
            o_BYTE        <= '0;
            o_BYTE_VALID  <= 1'b0;
            o_FRAME_DONE  <= 1'b0;
            o_PARTIAL     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            bit_cnt_reg   <= bit_cnt_next;
            shift_reg     <= shift_next;
            byte_seen_reg <= byte_seen_next;
            o_BYTE_VALID  <= byte_done;
            o_FRAME_DONE  <= frame_end;
            o_PARTIAL     <= partial_drop;
            if (byte_done) begin
                o_BYTE <= shift_word;
            end
        end
    end

    assign has_room = (o_N_received < 5'(N));
    assign o_FULL   = (o_N_received == 5'(N));

    // A clear coinciding with a completed byte restarts the buffer holding just that byte.
    always_ff @(posedge i_SCK) begin
        if (i_RST) begin
            o_N_received <= '0;
            o_OVERFLOW   <= 1'b0;
        end else if (i_CLEAR) begin
            o_N_received <= byte_done ? 5'd1 : 5'd0;
            o_OVERFLOW   <= 1'b0;
        end else if (byte_done) begin
            if (has_room) begin
                o_N_received <= o_N_received + 5'd1;
            end else begin
                o_OVERFLOW <= 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_slot
            logic [WIDTH-1:0] data_reg;
            logic             dc_reg;
            logic             write_en;

            assign write_en = byte_done &&
                              (i_CLEAR ? (gi == 0) : (o_N_received == 5'(gi)));

            always_ff @(posedge i_SCK) begin
                if (i_RST) begin
                    data_reg <= '0;
                    dc_reg   <= 1'b0;
                end else if (write_en) begin
                    data_reg <= shift_word;
                    dc_reg   <= i_DC;
                end else if (i_CLEAR) begin
                    data_reg <= '0;
                    dc_reg   <= 1'b0;
                end
            end

            assign o_DATA[WIDTH*gi +: WIDTH] = data_reg;
            assign o_DC[gi]                  = dc_reg;
        end
    endgenerate

endmodule

// File: tb/tb_spi_mosi_rx_buffer.sv
// Directed bench for spi_mosi_rx_buffer: single byte, back-to-back frame, overflow,
// partial byte, clear-on-completion and mid-byte reset.
module tb_spi_mosi_rx_buffer;

    localparam int WIDTH = 8;
    localparam int N     = 8;

    logic               i_SCK   = 1'b0;
    logic               i_RST   = 1'b1;
    logic               i_MOSI  = 1'b0;
    logic               i_CS    = 1'b1;
    logic               i_DC    = 1'b0;
    logic               i_CLEAR = 1'b0;
    logic [WIDTH*N-1:0] o_DATA;
    logic [N-1:0]       o_DC;
    logic [4:0]         o_N_received;
    logic [WIDTH-1:0]   o_BYTE;
    logic               o_BYTE_VALID;
    logic               o_FRAME_DONE;
    logic               o_FULL;
    logic               o_OVERFLOW;
    logic               o_PARTIAL;

    int tests = 0;
    int fails = 0;
    int bv_cnt = 0;
    int fd_cnt = 0;
    int pt_cnt = 0;
    int bv_base, fd_base, pt_base;

    logic [7:0] ov_bytes [9] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F, 8'hFE};

    spi_mosi_rx_buffer #(.WIDTH(WIDTH), .N(N)) dut (
        .i_SCK        (i_SCK),
        .i_RST        (i_RST),
        .i_MOSI       (i_MOSI),
        .i_CS         (i_CS),
        .i_DC         (i_DC),
        .i_CLEAR      (i_CLEAR),
        .o_DATA       (o_DATA),
        .o_DC         (o_DC),
        .o_N_received (o_N_received),
        .o_BYTE       (o_BYTE),
        .o_BYTE_VALID (o_BYTE_VALID),
        .o_FRAME_DONE (o_FRAME_DONE),
        .o_FULL       (o_FULL),
        .o_OVERFLOW   (o_OVERFLOW),
        .o_PARTIAL    (o_PARTIAL)
    );

    always #5 i_SCK = ~i_SCK;

    always @(negedge i_SCK) begin
        if (o_BYTE_VALID) bv_cnt <= bv_cnt + 1;
        if (o_FRAME_DONE) fd_cnt <= fd_cnt + 1;
        if (o_PARTIAL)    pt_cnt <= pt_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("[TB] ok   %s = 0x%0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge i_SCK);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic dc, input logic clr);
        for (int i = 7; i >= 0; i--) begin
            i_CS    = 1'b0;
            i_MOSI  = b[i];
            i_DC    = (i == 0) ? dc : 1'b0;
            i_CLEAR = (i == 0) ? clr : 1'b0;
            tick();
        end
        i_CLEAR = 1'b0;
        i_DC    = 1'b0;
    endtask

    task automatic end_frame();
        i_CS = 1'b1;
        tick();
    endtask

    task automatic clear_buf();
        i_CLEAR = 1'b1;
        tick();
        i_CLEAR = 1'b0;
    endtask

    task automatic snap();
        bv_base = bv_cnt;
        fd_base = fd_cnt;
        pt_base = pt_cnt;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " data"},  64'(o_DATA), 64'h0);
        check({tag, " dc"},    64'(o_DC), 64'h0);
        check({tag, " nrx"},   64'(o_N_received), 64'h0);
        check({tag, " byte"},  64'(o_BYTE), 64'h0);
        check({tag, " flags"}, 64'({o_BYTE_VALID, o_FRAME_DONE, o_OVERFLOW, o_PARTIAL, o_FULL}), 64'h0);
    endtask

    initial begin
        // Reset
        tick();
        tick();
        check_all_zero("reset");
        i_RST = 1'b0;
        tick();

        // Single byte 0xA5, DC=1
        snap();
        send_byte(8'hA5, 1'b1, 1'b0);
        check("s1 byte", 64'(o_BYTE), 64'hA5);
        check("s1 valid", 64'(o_BYTE_VALID), 64'h1);
        end_frame();
        check("s1 frame_done", 64'(o_FRAME_DONE), 64'h1);
        tick();
        check("s1 bv pulses", 64'(bv_cnt - bv_base), 64'd1);
        check("s1 fd pulses", 64'(fd_cnt - fd_base), 64'd1);
        check("s1 data0", 64'(o_DATA[7:0]), 64'hA5);
        check("s1 dc0", 64'(o_DC[0]), 64'h1);
        check("s1 nrx", 64'(o_N_received), 64'd1);
        clear_buf();
        check("clr nrx", 64'(o_N_received), 64'd0);
        check("clr data", 64'(o_DATA), 64'h0);

        // Four back-to-back bytes in one frame
        snap();
        send_byte(8'h03, 1'b0, 1'b0);
        send_byte(8'h0C, 1'b0, 1'b0);
        send_byte(8'h30, 1'b1, 1'b0);
        send_byte(8'hC0, 1'b1, 1'b0);
        end_frame();
        tick();
        check("s2 nrx", 64'(o_N_received), 64'd4);
        check("s2 data", 64'(o_DATA[31:0]), 64'hC0300C03);
        check("s2 dc", 64'(o_DC[3:0]), 64'hC);
        check("s2 bv pulses", 64'(bv_cnt - bv_base), 64'd4);
        check("s2 fd pulses", 64'(fd_cnt - fd_base), 64'd1);
        clear_buf();

        // Nine bytes into an eight-slot buffer
        for (int k = 0; k < 9; k++) begin
            send_byte(ov_bytes[k], 1'b0, 1'b0);
            if (k == 7) begin
                check("s3 full@8", 64'(o_FULL), 64'h1);
                check("s3 ovf@8", 64'(o_OVERFLOW), 64'h0);
            end
            if (k == 8) begin
                check("s3 ovf@9", 64'(o_OVERFLOW), 64'h1);
                check("s3 byte@9", 64'(o_BYTE), 64'hFE);
                check("s3 valid@9", 64'(o_BYTE_VALID), 64'h1);
            end
        end
        end_frame();
        check("s3 nrx", 64'(o_N_received), 64'd8);
        check("s3 data", 64'(o_DATA), 64'h7FBFDFEFF7FBFDFE);
        check("s3 ovf sticky", 64'(o_OVERFLOW), 64'h1);
        clear_buf();
        check("s3 clr ovf", 64'(o_OVERFLOW), 64'h0);
        check("s3 clr full", 64'(o_FULL), 64'h0);

        // Partial byte: five bits then CS high
        snap();
        for (int i = 0; i < 5; i++) begin
            i_CS   = 1'b0;
            i_MOSI = i[0];
            tick();
        end
        end_frame();
        check("s4 partial", 64'(o_PARTIAL), 64'h1);
        tick();
        check("s4 pt pulses", 64'(pt_cnt - pt_base), 64'd1);
        check("s4 bv pulses", 64'(bv_cnt - bv_base), 64'd0);
        check("s4 fd pulses", 64'(fd_cnt - fd_base), 64'd0);
        check("s4 nrx", 64'(o_N_received), 64'd0);
        send_byte(8'h3C, 1'b0, 1'b0);
        check("s4 next byte", 64'(o_BYTE), 64'h3C);
        end_frame();
        clear_buf();

        // Clear coinciding with completion of 0x55 while 3 bytes buffered
        send_byte(8'h11, 1'b1, 1'b0);
        send_byte(8'h22, 1'b1, 1'b0);
        send_byte(8'h33, 1'b1, 1'b0);
        check("s5 nrx pre", 64'(o_N_received), 64'd3);
        send_byte(8'h55, 1'b0, 1'b1);
        check("s5 nrx", 64'(o_N_received), 64'd1);
        check("s5 data", 64'(o_DATA), 64'h55);
        check("s5 dc", 64'(o_DC), 64'h0);
        check("s5 ovf", 64'(o_OVERFLOW), 64'h0);

        // Reset after four bits of a byte
        for (int i = 0; i < 4; i++) begin
            i_CS   = 1'b0;
            i_MOSI = 1'b1;
            tick();
        end
        snap();
        i_RST = 1'b1;
        tick();
        check_all_zero("s6 reset");
        i_RST = 1'b0;
        i_CS  = 1'b1;
        tick();
        check("s6 no partial", 64'(o_PARTIAL), 64'h0);
        check("s6 no fd", 64'(o_FRAME_DONE), 64'h0);
        send_byte(8'h81, 1'b1, 1'b0);
        check("s6 byte", 64'(o_BYTE), 64'h81);
        check("s6 data0", 64'(o_DATA[7:0]), 64'h81);
        check("s6 dc0", 64'(o_DC[0]), 64'h1);
        check("s6 nrx", 64'(o_N_received), 64'd1);
        end_frame();
        tick();
        check("s6 pt pulses", 64'(pt_cnt - pt_base), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
